// File: rtl/neo_spike_detector.sv
// Two-pass spike detector over the NEO energy buffer: the first pass forms an adaptive
// threshold from the buffer mean, and the second pass writes one refractory-gated flag per address.
module neo_spike_detector #(
   parameter int N        = 16,
   parameter int M        = 16,
   parameter int THR_MULT = 8,
   parameter int REFRACT  = 3
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic signed [N-1:0]   rdata,
   output logic [$clog2(M):0]    raddr,
   output logic                  flag_we,
   output logic [$clog2(M):0]    flag_addr,
   output logic                  flag,
   output logic signed [N+7:0]   threshold,
   output logic [$clog2(M):0]    spike_count,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            dbg_state
);

   localparam int LM = $clog2(M);
   localparam logic [LM-1:0] LAST = LM'(M - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SUM    = 3'd1,
      S_CALC   = 3'd2,
      S_DETECT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                  state;
   logic [LM-1:0]           idx;
   logic [LM-1:0]           refr;
   logic signed [N+LM-1:0]  acc;
   logic signed [N-1:0]     mean_n;
   logic [N+7:0]            thr_prod;
   logic signed [N+7:0]     rdata_ext;
   logic                    above;
   logic                    fire;

   // The mean of M N-bit samples always fits in N bits, so the floor shift reduces to a slice.
   always_comb begin
      mean_n    = acc[N+LM-1:LM];
      thr_prod  = {8'b0, mean_n} * (N+8)'(THR_MULT);
      rdata_ext = {{8{rdata[N-1]}}, rdata};
      above     = rdata_ext > threshold;
      fire      = (state == S_DETECT) && (refr == '0) && above;
   end

   always_comb begin
      raddr     = '0;
      flag_addr = '0;
      flag_we   = 1'b0;
      flag      = 1'b0;
      if (state == S_SUM) raddr = {1'b0, idx};
      if (state == S_DETECT) begin
         raddr     = {1'b0, idx};
         flag_addr = {1'b0, idx};
         flag_we   = 1'b1;
         flag      = fire;
      end
      busy      = (state == S_SUM) || (state == S_CALC) || (state == S_DETECT);
      done      = (state == S_DONE);
      dbg_state = state;
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         refr        <= '0;
         acc         <= '0;
         threshold   <= '0;
         spike_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_SUM;
                  idx         <= '0;
                  acc         <= '0;
                  spike_count <= '0;
               end
            end
            S_SUM: begin
               acc <= acc + {{LM{rdata[N-1]}}, rdata};
               if (idx == LAST) begin
                  idx   <= '0;
                  state <= S_CALC;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_CALC: begin
               // A negative mean clamps the threshold to zero.
               threshold <= acc[N+LM-1] ? '0 : $signed(thr_prod);
               refr      <= '0;
               state     <= S_DETECT;
            end
            S_DETECT: begin
               if (fire) begin
                  spike_count <= spike_count + 1'b1;
                  refr        <= LM'(REFRACT);
               end else if (refr != '0) begin
                  refr <= refr - 1'b1;
               end
               if (idx == LAST) begin
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Directed bench for neo_spike_detector: instance 0 uses the default parameters, and
// instance 1 (THR_MULT=1) covers the refractory case. Both instances share one energy buffer.
module tb_neo_spike_detector;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic reset;
   logic start0, start1;
   logic signed [15:0] buf_mem [16];

   logic signed [15:0] rdata0, rdata1;
   logic [4:0]  raddr0, raddr1, flag_addr0, flag_addr1, spike_count0, spike_count1;
   logic        flag_we0, flag_we1, flag0, flag1, busy0, busy1, done0, done1;
   logic signed [23:0] threshold0, threshold1;
   logic [2:0]  state0, state1;

   assign rdata0 = buf_mem[raddr0[3:0]];
   assign rdata1 = buf_mem[raddr1[3:0]];

   neo_spike_detector dut0 (
      .Clk(Clk), .reset(reset), .start(start0), .rdata(rdata0), .raddr(raddr0),
      .flag_we(flag_we0), .flag_addr(flag_addr0), .flag(flag0), .threshold(threshold0),
      .spike_count(spike_count0), .busy(busy0), .done(done0), .dbg_state(state0)
   );

   neo_spike_detector #(.N(16), .M(16), .THR_MULT(1), .REFRACT(3)) dut1 (
      .Clk(Clk), .reset(reset), .start(start1), .rdata(rdata1), .raddr(raddr1),
      .flag_we(flag_we1), .flag_addr(flag_addr1), .flag(flag1), .threshold(threshold1),
      .spike_count(spike_count1), .busy(busy1), .done(done1), .dbg_state(state1)
   );

   // Flag memories
   logic [15:0] fvec0 = '0, fvec1 = '0;
   int wr0 = 0, wr1 = 0;
   always @(posedge Clk) begin
      if (flag_we0) begin fvec0[flag_addr0[3:0]] <= flag0; wr0 <= wr0 + 1; end
      if (flag_we1) begin fvec1[flag_addr1[3:0]] <= flag1; wr1 <= wr1 + 1; end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < 16; i++) buf_mem[i] = 16'(v);
   endtask

   // Full run on one instance; checks latency, busy, the done pulse, results and flag writes.
   task automatic do_run(input int inst, input string tag, input int exp_thr,
                         input int exp_sc, input logic [15:0] exp_vec);
      int lat, wb;
      logic bz_first, bz_done, d;
      wb = (inst == 0) ? wr0 : wr1;
      @(negedge Clk);
      if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge Clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      lat = 0; bz_first = 1'b0; bz_done = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         @(negedge Clk);
         if (j == 1) bz_first = (inst == 0) ? busy0 : busy1;
         d = (inst == 0) ? done0 : done1;
         if (d) begin
            lat = j;
            bz_done = (inst == 0) ? busy0 : busy1;
            break;
         end
      end
      check({tag, "_latency"}, lat, 34);
      check({tag, "_busy_rise"}, {31'b0, bz_first}, 1);
      check({tag, "_busy_at_done"}, {31'b0, bz_done}, 0);
      @(negedge Clk);
      check({tag, "_done_pulse"}, {31'b0, (inst == 0) ? done0 : done1}, 0);
      check({tag, "_threshold"}, (inst == 0) ? 32'(threshold0) : 32'(threshold1), 32'(exp_thr));
      check({tag, "_spike_count"}, (inst == 0) ? 32'(spike_count0) : 32'(spike_count1), 32'(exp_sc));
      check({tag, "_flags"}, (inst == 0) ? 32'(fvec0) : 32'(fvec1), {16'b0, exp_vec});
      check({tag, "_writes"}, ((inst == 0) ? wr0 : wr1) - wb, 16);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"},        {31'b0, busy0}, 0);
      check({tag, "_done"},        {31'b0, done0}, 0);
      check({tag, "_raddr"},       32'(raddr0), 0);
      check({tag, "_flag_we"},     {31'b0, flag_we0}, 0);
      check({tag, "_flag_addr"},   32'(flag_addr0), 0);
      check({tag, "_flag"},        {31'b0, flag0}, 0);
      check({tag, "_threshold"},   32'(threshold0), 0);
      check({tag, "_spike_count"}, 32'(spike_count0), 0);
      check({tag, "_state"},       32'(state0), 0);
   endtask

   initial begin
      int ndone, first;
      reset = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      fill(0);
      repeat (2) @(negedge Clk);
      check_zero_outputs("reset");
      check("reset_busy1", {31'b0, busy1}, 0);
      reset = 1'b1;
      @(negedge Clk);

      // All-zero buffer
      fill(0);
      do_run(0, "zero", 0, 0, 16'h0000);

      // Single spike: sum 1150, mean 71, threshold 568
      fill(10);
      buf_mem[5] = 16'sd1000;
      do_run(0, "single", 568, 1, 16'h0020);

      // Refractory: mean 312, addrs 4..6 suppressed after addr 3
      fill(0);
      for (int i = 3; i <= 7; i++) buf_mem[i] = 16'sd1000;
      do_run(1, "refract", 312, 2, 16'h0088);

      // Negative mean: sum -1450, mean -91, threshold clamps to 0
      fill(-100);
      buf_mem[9] = 16'sd50;
      do_run(0, "negmean", 0, 1, 16'h0200);

      // Start pulsed again while busy must be ignored
      fill(10);
      buf_mem[5] = 16'sd1000;
      @(negedge Clk);
      start0 = 1'b1;
      @(posedge Clk);
      #1;
      start0 = 1'b0;
      ndone = 0; first = 0;
      for (int j = 1; j <= 80; j++) begin
         @(negedge Clk);
         start0 = (j == 10);
         if (done0) begin
            ndone++;
            if (first == 0) first = j;
         end
      end
      start0 = 1'b0;
      check("busy_start_ndone", ndone, 1);
      check("busy_start_first", first, 34);
      check("busy_start_sc", 32'(spike_count0), 1);
      check("busy_start_idle", {31'b0, busy0}, 0);

      // Reset mid-DETECT aborts the run with no done pulse
      @(negedge Clk);
      start0 = 1'b1;
      @(posedge Clk);
      #1;
      start0 = 1'b0;
      for (int j = 1; j <= 20; j++) @(negedge Clk);
      check("midrst_busy_before", {31'b0, busy0}, 1);
      reset = 1'b0;
      #1;
      check_zero_outputs("midrst");
      @(negedge Clk);
      reset = 1'b1;
      ndone = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge Clk);
         if (done0) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      do_run(0, "after_rst", 568, 1, 16'h0020);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/neo_spike_detector.md
# neo_spike_detector

Downstream stage of the NEO energy calculator. Once the calculator has filled the NEO energy buffer with M samples, this block reads the buffer twice. The first pass forms an adaptive threshold equal to the buffer mean times THR_MULT. The second pass compares each sample against that threshold and writes one spike flag per address, with a refractory hold-off. It reports the threshold, the spike count and a done pulse to the controller.

## Interface
- N, default 16: width of the signed NEO energy samples.
- M, default 16: buffer depth; must be a power of 2.
- THR_MULT, default 8: unsigned threshold multiplier, range 1..255.
- REFRACT, default 3: number of samples suppressed after each flagged spike, range 0..M-1.

Ports (reset is asynchronous, active-low; clock is Clk):
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a detection run; sampled in IDLE only.
- rdata  in  N signed  energy buffer read data; combinational read, valid in the same cycle as raddr.
- raddr  out  $clog2(M)+1  energy buffer read address.
- flag_we  out  1  flag memory write enable.
- flag_addr  out  $clog2(M)+1  flag memory write address.
- flag  out  1  spike flag write data.
- threshold  out  N+8 signed  threshold of the last run; held until the next CALC.
- spike_count  out  $clog2(M)+1  number of flags set in the current or last run.
- busy  out  1  high in SUM, CALC and DETECT.
- done  out  1  single-cycle pulse at the end of a run.

## Operation
- **State machine:** IDLE -> SUM -> CALC -> DETECT -> DONE -> IDLE.
- **IDLE:**
  - start=1 -> SUM.
  - The transition clears idx, the accumulator and spike_count.
- **SUM:**
  - raddr = idx.
  - acc += sign-extended rdata. acc is N+$clog2(M) bits signed.
  - idx increments each cycle. After idx = M-1: -> CALC, idx = 0.
- **CALC:** single cycle.
  - mean = acc >>> $clog2(M), an arithmetic shift that rounds toward -inf.
  - If mean < 0, threshold = 0.
  - Otherwise threshold = mean * THR_MULT. This cannot overflow N+8 bits.
  - Clear refr. -> DETECT.
- **DETECT:**
  - raddr = flag_addr = idx; flag_we = 1.
  - above = (sign-extended rdata > threshold). The comparison is strict.
  - If refr == 0 and above: flag = 1, spike_count += 1, refr = REFRACT.
  - Otherwise: flag = 0, and refr decrements if it is nonzero.
  - After idx = M-1: -> DONE.
- **DONE:** done = 1 for one cycle. -> IDLE.
- **start handling:** start is ignored outside IDLE. A start that is still high in the first IDLE cycle after DONE begins a new run.
- **Count width:** spike_count never exceeds M, so it needs no saturation logic.
- **Idle outputs:**
  - flag_we and flag are 0 outside DETECT.
  - raddr and flag_addr read 0 outside SUM and DETECT.
- **Output hold:** threshold and spike_count hold their values after DONE until the next start or reset.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
- **Asynchronous reset:** takes effect immediately in any state. A mid-run reset aborts without a done pulse. Any flags already written stay in the flag memory.
- **Run timeline:** with start sampled at edge k:
  - SUM occupies cycles k+1 .. k+M.
  - CALC occupies cycle k+M+1.
  - DETECT occupies cycles k+M+2 .. k+2M+1, with one flag write per cycle.
  - done is high in cycle k+2M+2. For M=16 that is 34 cycles after the start edge.
- **busy:** rises in cycle k+1 and falls when DONE is entered. It is low in the done cycle.
- **Flag write:** the flag for address a is written at the clock edge that ends DETECT cycle a.
- **Input stability:** the upstream stage must not write the energy buffer while busy = 1.

## Test plan
- **All-zero buffer, defaults:** threshold = 0; 16 writes with flag = 0; spike_count = 0; done exactly 34 cycles after start.
- **Single spike:** buffer all 10 except addr 5 = 1000; THR_MULT = 8.
  - sum = 1150, mean = 71, threshold = 568.
  - Only addr 5 is flagged; spike_count = 1.
- **Refractory:** addrs 3-7 = 1000, rest 0; THR_MULT = 1, REFRACT = 3.
  - mean = 312, so threshold = 312.
  - Addrs 3 and 7 are flagged; addrs 4-6 are suppressed; spike_count = 2.
- **Negative mean:** all -100 except addr 9 = 50.
  - sum = -1450, mean = -91, threshold clamps to 0.
  - Only addr 9 is flagged; spike_count = 1.
- **Start while busy:** pulse start again at cycle k+10.
  - Exactly one run occurs, and done appears only at k+34.
- **Reset mid-DETECT:** assert reset in cycle k+20.
  - All outputs go to 0 immediately and no done pulse appears.
  - A following start produces a complete, correct run.
